game_scheduler: RTL
===================

GAME_SCHEDULER -- requirements
Module: game_scheduler

Interface
REQ-001 Parameter SCREEN_W, default 640, visible pixel columns.
REQ-002 Parameter BASKET_Y, default 450, top row of the basket (catch line).
REQ-003 Parameter FLOOR_Y, default 479, last visible row (miss line).
REQ-004 Parameter HALF_W, default 50, basket half-width in pixels.
REQ-005 Parameter BASKET_STEP, default 4, basket pixels moved per frame.
REQ-006 Parameter FALL_STEP, default 2, fruit pixels fallen per frame.
REQ-007 Parameter SPAWN_PERIOD, default 60, frames between spawn attempts.
REQ-008 Parameter LIVES_INIT, default 3, lives at game start.
REQ-009 Clock  input  1  sole clock; all state updates on the rising edge.
REQ-010 Resetn  input  1  asynchronous, active-low reset.
REQ-011 FrameTick  input  1  one-cycle pulse per video frame.
REQ-012 Start  input  1  level; starts a game from IDLE or OVER.
REQ-013 MoveRight  input  1  player right button.
REQ-014 MoveLeft  input  1  player left button.
REQ-015 BasketX  output  10  basket centre column.
REQ-016 FruitActive  output  4  per-slot valid bit; bit i is slot i.
REQ-017 FruitX  output  40  packed slot columns; slot i at bits [10i+9:10i].
REQ-018 FruitY  output  40  packed slot rows; slot i at bits [10i+9:10i].
REQ-019 Score  output  8  fruits caught.
REQ-020 Lives  output  2  remaining lives.
REQ-021 State  output  2  IDLE=0, PLAY=1, UPDATE=2, OVER=3.

Function
REQ-022 FSM transitions:
- IDLE -> PLAY on Start.
- PLAY -> UPDATE on FrameTick.
- UPDATE -> PLAY after the sweep, or -> OVER if Lives=0.
- OVER -> PLAY on Start.
- FrameTick is ignored outside PLAY.
REQ-023 Entering PLAY from IDLE or OVER loads the game-start values: Score=0, Lives=LIVES_INIT, BasketX=320, FruitActive=0, spawn counter=0.
REQ-024 UPDATE lasts exactly 6 cycles, one step per cycle:
- cycle 0: basket move;
- cycles 1-4: slots 0-3 in order;
- cycle 5: spawn.
REQ-025 Basket move depends only on the MoveRight and MoveLeft values sampled in cycle 0:
- MoveRight only: BasketX += BASKET_STEP, saturating at SCREEN_W-1-HALF_W (589).
- MoveLeft only: BasketX -= BASKET_STEP, saturating at HALF_W (50).
- Both or neither: BasketX holds.
REQ-026 Slot step, inactive slot: no change.
REQ-027 Slot step, active slot: compute Y' = FruitY + FALL_STEP, then apply the first matching rule:
- caught: Y' >= BASKET_Y and |FruitX - BasketX| < HALF_W, using the BasketX updated in cycle 0 and 11-bit signed compare → slot cleared; Score += 1, saturating at 255.
- missed: Y' >= FLOOR_Y → slot cleared; Lives -= 1, not below 0.
- otherwise: FruitY = Y'.
REQ-028 Spawn step: spawn counter increments; when it reaches SPAWN_PERIOD it returns to 0.
REQ-029 On that wrap, the lowest-index inactive slot is activated with FruitY=0 and FruitX = 64 + lfsr[8:0] (range 64..575).
REQ-030 On wrap with all slots active, no spawn occurs and the counter still wraps.
REQ-031 LFSR: 10-bit, polynomial x^10+x^7+1, advances every clock in all states, seed 10'h2A5, never all-zero.
REQ-032 Two misses in one sweep each decrement Lives; the Lives=0 check is taken at the end of cycle 5, so the full sweep completes first.
REQ-033 OVER and IDLE hold all outputs unchanged except the LFSR.
REQ-034 Start held high in PLAY or UPDATE has no effect.

Reset
REQ-035 Resetn low asynchronously forces: State=IDLE, BasketX=320, FruitActive=0, FruitX=0, FruitY=0, Score=0, Lives=LIVES_INIT, spawn counter=0, LFSR=10'h2A5.
REQ-036 Reset asserted during UPDATE abandons the sweep; the first edge after release evaluates in IDLE.

Verification
REQ-037 Reset, then Start, then 60 FrameTicks with no buttons → slot 0 active, FruitY=0, FruitX in 64..575, State returns to PLAY 6 cycles after each tick.
REQ-038 BasketX=588 with MoveRight held, one tick → BasketX=589; another tick → 589. Mirror case: BasketX=52 with MoveLeft → 50.
REQ-039 Fruit at X=320, Y=448, BasketX=320, one tick → slot cleared, Score=1, Lives unchanged.
REQ-040 Fruit at X=500, Y=478, BasketX=320, Lives=1, one tick → slot cleared, Lives=0, State=OVER; a later Start → PLAY with Score=0, Lives=3.
REQ-041 All 4 slots active at the spawn wrap → no slot change; spawn counter=0.
REQ-042 Resetn pulsed low in UPDATE cycle 3 → all REQ-035 values immediately; a FrameTick after release is ignored (State stays IDLE).

Source files
------------

// File: rtl/game_scheduler.sv
// Fruit-catching game scheduler: four falling fruit slots, one movable basket,
// and a per-frame update sweep that steps basket, slots and spawner in turn.
module game_scheduler #(
    parameter int SCREEN_W     = 640,
    parameter int BASKET_Y     = 450,
    parameter int FLOOR_Y      = 479,
    parameter int HALF_W       = 50,
    parameter int BASKET_STEP  = 4,
    parameter int FALL_STEP    = 2,
    parameter int SPAWN_PERIOD = 60,
    parameter int LIVES_INIT   = 3
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        FrameTick,
    input  logic        Start,
    input  logic        MoveRight,
    input  logic        MoveLeft,
    output logic [9:0]  BasketX,
    output logic [3:0]  FruitActive,
    output logic [39:0] FruitX,
    output logic [39:0] FruitY,
    output logic [7:0]  Score,
    output logic [1:0]  Lives,
    output logic [1:0]  State
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PLAY   = 2'd1,
        S_UPDATE = 2'd2,
        S_OVER   = 2'd3
    } state_e;

    localparam int            CW       = $clog2(SPAWN_PERIOD + 1);
    localparam logic [9:0]    X_HOME   = 10'd320;
    localparam logic [9:0]    X_MAX    = 10'(SCREEN_W - 1 - HALF_W);
    localparam logic [9:0]    X_MIN    = 10'(HALF_W);
    localparam logic [9:0]    X_STEP   = 10'(BASKET_STEP);
    localparam logic [9:0]    X_HI_LIM = 10'(SCREEN_W - 1 - HALF_W - BASKET_STEP);
    localparam logic [9:0]    X_LO_LIM = 10'(HALF_W + BASKET_STEP);
    localparam logic [CW-1:0] CNT_WRAP = CW'(SPAWN_PERIOD);

    state_e        state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [9:0]    lfsr_q, lfsr_d;
    logic [9:0]    basket_q, basket_d;
    logic [3:0]    active_q, active_d;
    logic [9:0]    fx_q [4];
    logic [9:0]    fx_d [4];
    logic [9:0]    fy_q [4];
    logic [9:0]    fy_d [4];
    logic [7:0]    score_q, score_d;
    logic [1:0]    lives_q, lives_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Slot under evaluation in sweep cycles 1..4; basket_q already holds this frame's move.
    logic [1:0]         slot_idx;
    logic [10:0]        y_next;
    logic signed [10:0] dx;
    logic [10:0]        dx_abs;
    logic               caught, missed;

    assign slot_idx = 2'(step_q - 3'd1);
    assign y_next   = {1'b0, fy_q[slot_idx]} + 11'(FALL_STEP);
    assign dx       = $signed({1'b0, fx_q[slot_idx]}) - $signed({1'b0, basket_q});
    assign dx_abs   = dx[10] ? (~dx + 11'd1) : dx;
    assign caught   = (y_next >= 11'(BASKET_Y)) && (dx_abs < 11'(HALF_W));
    assign missed   = (y_next >= 11'(FLOOR_Y));

    logic [1:0]    free_idx;
    logic          any_free;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        free_idx = 2'd0;
        any_free = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!active_q[i]) begin
                free_idx = 2'(i);
                any_free = 1'b1;
            end
        end
    end

    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        lfsr_d   = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        basket_d = basket_q;
        active_d = active_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        score_d  = score_q;
        lives_d  = lives_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (Start) begin
                    state_d  = S_PLAY;
                    score_d  = 8'd0;
                    lives_d  = 2'(LIVES_INIT);
                    basket_d = X_HOME;
                    active_d = 4'd0;
                    cnt_d    = '0;
                end
            end
            S_PLAY: begin
                if (FrameTick) begin
                    state_d = S_UPDATE;
                    step_d  = 3'd0;
                end
            end
            default: begin
                step_d = step_q + 3'd1;
                case (step_q)
                    3'd0: begin
                        if (MoveRight && !MoveLeft)
                            basket_d = (basket_q >= X_HI_LIM) ? X_MAX : basket_q + X_STEP;
                        else if (MoveLeft && !MoveRight)
                            basket_d = (basket_q <= X_LO_LIM) ? X_MIN : basket_q - X_STEP;
                    end
                    3'd1, 3'd2, 3'd3, 3'd4: begin
                        if (active_q[slot_idx]) begin
                            if (caught) begin
                                active_d[slot_idx] = 1'b0;
                                if (score_q != 8'hFF) score_d = score_q + 8'd1;
                            end else if (missed) begin
                                active_d[slot_idx] = 1'b0;
                                if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
                            end else begin
                                fy_d[slot_idx] = 10'(y_next);
                            end
                        end
                    end
                    default: begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_WRAP) begin
                            cnt_d = '0;
                            if (any_free) begin
                                active_d[free_idx] = 1'b1;
                                fy_d[free_idx]     = 10'd0;
                                fx_d[free_idx]     = 10'd64 + {1'b0, lfsr_q[8:0]};
                            end
                        end
                        step_d  = 3'd0;
                        state_d = (lives_q == 2'd0) ? S_OVER : S_PLAY;
                    end
                endcase
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= S_IDLE;
            step_q   <= 3'd0;
            lfsr_q   <= 10'h2A5;
            basket_q <= X_HOME;
            active_q <= 4'd0;
            score_q  <= 8'd0;
            lives_q  <= 2'(LIVES_INIT);
            cnt_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                fx_q[i] <= 10'd0;
                fy_q[i] <= 10'd0;
            end
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            lfsr_q   <= lfsr_d;
            basket_q <= basket_d;
            active_q <= active_d;
            score_q  <= score_d;
            lives_q  <= lives_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < 4; i++) begin
                fx_q[i] <= fx_d[i];
                fy_q[i] <= fy_d[i];
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign FruitX[10*g +: 10] = fx_q[g];
        assign FruitY[10*g +: 10] = fy_q[g];
    end

    assign BasketX     = basket_q;
    assign FruitActive = active_q;
    assign Score       = score_q;
    assign Lives       = lives_q;
    assign State       = state_q;
endmodule
